next_pc_unit: RTL and testbench

Parametrised fetch-address generator that replaces the purely combinational jump/branch target adder with a registered program counter. It holds the fetch PC, advances it sequentially, and applies stall and EX-stage redirects (taken branch, `j`/`jal`, `jr`) with a fixed priority. A small circular return-address stack (RAS) supplies `jr $ra` targets. It sits at the head of the IF stage and feeds the instruction memory and the IF/ID register.

---
 rtl/next_pc_unit.sv | 109 ++++++++++
 tb/tb_next_pc_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// Registered fetch-PC generator. It handles sequential advance, stall, and EX-stage redirects (jr > jmp > branch).
// A small circular return-address stack supplies jr $ra targets.
module next_pc_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stall,
    input  logic [ADDR_W-1:0]              ex_pc4,
    input  logic [31:0]                    ex_offset,
    input  logic [25:0]                    ex_index,
    input  logic                           br_taken,
    input  logic                           jmp,
    input  logic                           jal,
    input  logic                           jr,
    input  logic                           use_ras,
    input  logic [ADDR_W-1:0]              jr_target,
    output logic [ADDR_W-1:0]              pc_o,
    output logic [ADDR_W-1:0]              pc4_o,
    output logic                           flush_o,
    output logic                           ras_miss_o,
    output logic [$clog2(RAS_DEPTH):0]     ras_count_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic              flush_q, miss_q;
    logic [PW-1:0]     tp_q, tp_nxt, wr_idx;
    logic [CW-1:0]     cnt_q, cnt_nxt;
    logic [ADDR_W-1:0] ras [RAS_DEPTH];

    logic [ADDR_W-1:0] off_ext, br_tgt, jmp_tgt, jr_tgt, ras_top;
    logic              redirect, push, pop, empty;

    // Signed cast sign-extends or truncates the immediate to ADDR_W before scaling.
    assign off_ext = ADDR_W'($signed(ex_offset));
    assign br_tgt  = ex_pc4 + (off_ext << 2);

    generate
        if (ADDR_W > 28) begin : g_jmp_hi
            assign jmp_tgt = {ex_pc4[ADDR_W-1:28], ex_index, 2'b00};
        end else begin : g_jmp_lo
            assign jmp_tgt = {ex_index, 2'b00};
        end
    endgenerate

    assign empty    = (cnt_q == '0);
    assign ras_top  = ras[tp_q];
    assign push     = jal && (jmp || jr);
    assign pop      = jr && use_ras;
    assign jr_tgt   = (use_ras && !empty) ? ras_top : jr_target;
    assign redirect = jr || jmp || br_taken;

    always_comb begin
        pc_nxt = pc_q + ADDR_W'(4);
        if (jr)            pc_nxt = jr_tgt;
        else if (jmp)      pc_nxt = jmp_tgt;
        else if (br_taken) pc_nxt = br_tgt;
        else if (stall)    pc_nxt = pc_q;
    end

    // A jalr that hits the stack swaps the top in place; a miss-plus-push behaves as a plain push.
    always_comb begin
        tp_nxt  = tp_q;
        cnt_nxt = cnt_q;
        wr_idx  = tp_q + 1'b1;
        if (push && pop && !empty) begin
            wr_idx = tp_q;
        end else if (push) begin
            tp_nxt  = tp_q + 1'b1;
            cnt_nxt = (cnt_q == FULL) ? FULL : cnt_q + 1'b1;
        end else if (pop && !empty) begin
            tp_nxt  = tp_q - 1'b1;
            cnt_nxt = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= ADDR_W'(RESET_PC);
            flush_q <= 1'b0;
            miss_q  <= 1'b0;
            tp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_nxt;
            flush_q <= redirect;
            miss_q  <= pop && empty;
            tp_q    <= tp_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) ras[wr_idx] <= ex_pc4;
    end

    assign pc_o        = pc_q;
    assign pc4_o       = pc_q + ADDR_W'(4);
    assign flush_o     = flush_q;
    assign ras_miss_o  = miss_q;
    assign ras_count_o = cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: sequence, stall/branch, priority, RAS overflow/underflow/jalr, reset, wrap.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, br_taken, jmp, jal, jr, use_ras;
    logic [31:0] ex_pc4, ex_offset, jr_target;
    logic [25:0] ex_index;
    logic [31:0] pc_o, pc4_o;
    logic        flush_o, ras_miss_o;
    logic [2:0]  ras_count_o;

    int total_cnt = 0;
    int pass_cnt  = 0;

    next_pc_unit #(.ADDR_W(32), .RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_pc4(ex_pc4), .ex_offset(ex_offset),
        .ex_index(ex_index), .br_taken(br_taken), .jmp(jmp), .jal(jal), .jr(jr),
        .use_ras(use_ras), .jr_target(jr_target), .pc_o(pc_o), .pc4_o(pc4_o),
        .flush_o(flush_o), .ras_miss_o(ras_miss_o), .ras_count_o(ras_count_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; br_taken = 0; jmp = 0; jal = 0; jr = 0; use_ras = 0;
        ex_pc4 = 0; ex_offset = 0; ex_index = 0; jr_target = 0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        rst_n = 0;
        idle_inputs();
        step(); step();
        total_cnt++;
        if (pc_o !== 32'h0 || flush_o !== 1'b0 || ras_miss_o !== 1'b0 || ras_count_o !== 3'd0)
            $display("FAIL reset_state pc=%h flush=%b miss=%b cnt=%0d expected pc=0 flush=0 miss=0 cnt=0",
                     pc_o, flush_o, ras_miss_o, ras_count_o);
        else pass_cnt++;
        rst_n = 1;
        exp_pc = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_pc = exp_pc + 4;
            total_cnt++;
            if (pc_o !== exp_pc || flush_o !== 1'b0)
                $display("FAIL seq_%0d pc=%h flush=%b expected pc=%h flush=0", i, pc_o, flush_o, exp_pc);
            else pass_cnt++;
        end
        total_cnt++;
        if (pc4_o !== 32'h14) $display("FAIL pc4_o got %h expected 00000014", pc4_o);
        else pass_cnt++;
    endtask

    task automatic test_branch_stall();
        stall = 1; br_taken = 1; ex_pc4 = 32'h0C; ex_offset = 32'hFFFF_FFFE;
        step();
        total_cnt++;
        if (pc_o !== 32'h04 || flush_o !== 1'b1)
            $display("FAIL branch_over_stall pc=%h flush=%b expected pc=00000004 flush=1", pc_o, flush_o);
        else pass_cnt++;
        br_taken = 0;
        step();
        total_cnt++;
        if (pc_o !== 32'h04 || flush_o !== 1'b0)
            $display("FAIL stall_hold pc=%h flush=%b expected pc=00000004 flush=0", pc_o, flush_o);
        else pass_cnt++;
        stall = 0;
        step();
        total_cnt++;
        if (pc_o !== 32'h08) $display("FAIL stall_release pc=%h expected 00000008", pc_o);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        jr = 1; jmp = 1; br_taken = 1; jr_target = 32'h400; ex_pc4 = 32'hA000_0000;
        ex_index = 26'h10; ex_offset = 32'h3;
        step();
        total_cnt++;
        if (pc_o !== 32'h400 || flush_o !== 1'b1)
            $display("FAIL prio_jr pc=%h flush=%b expected pc=00000400 flush=1", pc_o, flush_o);
        else pass_cnt++;
        jr = 0;
        step();
        total_cnt++;
        if (pc_o !== 32'hA000_0040 || flush_o !== 1'b1)
            $display("FAIL prio_jmp pc=%h flush=%b expected pc=a0000040 flush=1", pc_o, flush_o);
        else pass_cnt++;
        jmp = 0; ex_pc4 = 32'h100;
        step();
        total_cnt++;
        if (pc_o !== 32'h10C || flush_o !== 1'b1)
            $display("FAIL prio_branch pc=%h flush=%b expected pc=0000010c flush=1", pc_o, flush_o);
        else pass_cnt++;
        idle_inputs();
        step();
        total_cnt++;
        if (pc_o !== 32'h110 || flush_o !== 1'b0)
            $display("FAIL after_redirect pc=%h flush=%b expected pc=00000110 flush=0", pc_o, flush_o);
        else pass_cnt++;
    endtask

    task automatic test_ras_overflow();
        logic [31:0] pops [4];
        pops[0] = 32'h504; pops[1] = 32'h404; pops[2] = 32'h304; pops[3] = 32'h204;
        for (int i = 0; i < 5; i++) begin
            jmp = 1; jal = 1; ex_index = 26'h40; ex_pc4 = 32'h104 + 32'(i) * 32'h100;
            step();
            total_cnt++;
            if (pc_o !== 32'h100 || ras_count_o !== 3'((i + 1 > 4) ? 4 : i + 1))
                $display("FAIL push_%0d pc=%h cnt=%0d expected pc=00000100 cnt=%0d",
                         i, pc_o, ras_count_o, (i + 1 > 4) ? 4 : i + 1);
            else pass_cnt++;
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            jr = 1; use_ras = 1; jr_target = 32'h999;
            step();
            total_cnt++;
            if (pc_o !== pops[i] || ras_count_o !== 3'(3 - i) || ras_miss_o !== 1'b0)
                $display("FAIL pop_%0d pc=%h cnt=%0d miss=%b expected pc=%h cnt=%0d miss=0",
                         i, pc_o, ras_count_o, ras_miss_o, pops[i], 3 - i);
            else pass_cnt++;
        end
    endtask

    task automatic test_empty_pop();
        jr = 1; use_ras = 1; jr_target = 32'h888;
        step();
        total_cnt++;
        if (pc_o !== 32'h888 || ras_miss_o !== 1'b1 || flush_o !== 1'b1 || ras_count_o !== 3'd0)
            $display("FAIL empty_pop pc=%h miss=%b flush=%b cnt=%0d expected pc=00000888 miss=1 flush=1 cnt=0",
                     pc_o, ras_miss_o, flush_o, ras_count_o);
        else pass_cnt++;
        idle_inputs();
        step();
        total_cnt++;
        if (ras_miss_o !== 1'b0) $display("FAIL miss_pulse_end miss=%b expected 0", ras_miss_o);
        else pass_cnt++;
    endtask

    task automatic test_jalr();
        jmp = 1; jal = 1; ex_pc4 = 32'h300; ex_index = 26'h80;
        step();
        idle_inputs();
        jr = 1; jal = 1; use_ras = 1; ex_pc4 = 32'h704; jr_target = 32'h999;
        step();
        total_cnt++;
        if (pc_o !== 32'h300 || ras_count_o !== 3'd1)
            $display("FAIL jalr_hit pc=%h cnt=%0d expected pc=00000300 cnt=1", pc_o, ras_count_o);
        else pass_cnt++;
        jal = 0;
        step();
        total_cnt++;
        if (pc_o !== 32'h704 || ras_count_o !== 3'd0)
            $display("FAIL jalr_replaced_top pc=%h cnt=%0d expected pc=00000704 cnt=0", pc_o, ras_count_o);
        else pass_cnt++;
        jal = 1; ex_pc4 = 32'h904; jr_target = 32'h888;
        step();
        total_cnt++;
        if (pc_o !== 32'h888 || ras_miss_o !== 1'b1 || ras_count_o !== 3'd1)
            $display("FAIL jalr_empty pc=%h miss=%b cnt=%0d expected pc=00000888 miss=1 cnt=1",
                     pc_o, ras_miss_o, ras_count_o);
        else pass_cnt++;
        jal = 0; jr_target = 32'h999;
        step();
        total_cnt++;
        if (pc_o !== 32'h904 || ras_count_o !== 3'd0 || ras_miss_o !== 1'b0)
            $display("FAIL jalr_empty_pushed pc=%h cnt=%0d miss=%b expected pc=00000904 cnt=0 miss=0",
                     pc_o, ras_count_o, ras_miss_o);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        jmp = 1; jal = 1; ex_pc4 = 32'h124; ex_index = 26'h20;
        step();
        idle_inputs();
        rst_n = 0; br_taken = 1; ex_pc4 = 32'h100; ex_offset = 32'h4;
        step();
        total_cnt++;
        if (pc_o !== 32'h0 || flush_o !== 1'b0 || ras_count_o !== 3'd0 || ras_miss_o !== 1'b0)
            $display("FAIL mid_reset pc=%h flush=%b cnt=%0d miss=%b expected pc=0 flush=0 cnt=0 miss=0",
                     pc_o, flush_o, ras_count_o, ras_miss_o);
        else pass_cnt++;
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_wrap();
        jr = 1; jr_target = 32'hFFFF_FFF8;
        step();
        idle_inputs();
        step();
        total_cnt++;
        if (pc_o !== 32'hFFFF_FFFC || pc4_o !== 32'h0)
            $display("FAIL wrap_edge pc=%h pc4=%h expected pc=fffffffc pc4=00000000", pc_o, pc4_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (pc_o !== 32'h0 || flush_o !== 1'b0)
            $display("FAIL wrap_zero pc=%h flush=%b expected pc=0 flush=0", pc_o, flush_o);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_branch_stall();
        test_priority();
        test_ras_overflow();
        test_empty_pop();
        test_jalr();
        test_mid_reset();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
